mem_arbiter: RTL and testbench

- Sequences and shares the single byte-wide RAM port between two requesters: the instruction cache (32-bit fetches) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each transaction into byte beats and arbitrates round-robin between the two requesters.
- Honours pipeline flush and IO back-pressure.
- Sits between icache/LSB and the top-level memory bus.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Purpose: groups the icache, load/store-buffer and RAM-side signals of the
//          memory arbiter into one bundle.
// Ports (signals):
//   mem_din / mem_dout / mem_a / mem_wr       byte-wide RAM port
//   if_req / if_addr / if_done / if_data      icache fetch handshake
//   ls_req / ls_wr / ls_addr / ls_size /
//   ls_wdata / ls_done / ls_rdata             load/store buffer handshake
// Modports:
//   slave  - the arbiter itself
//   master - requesters plus RAM (the environment around the arbiter)
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_data;

    logic                  ls_req;
    logic                  ls_wr;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [1:0]            ls_size;
    logic [31:0]           ls_wdata;
    logic                  ls_done;
    logic [31:0]           ls_rdata;

    modport slave (
        input  mem_din, if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        output mem_dout, mem_a, mem_wr, if_done, if_data, ls_done, ls_rdata
    );

    modport master (
        output mem_din, if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        input  mem_dout, mem_a, mem_wr, if_done, if_data, ls_done, ls_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Purpose: shares one byte-wide RAM port between the icache (32-bit fetches)
//          and the load/store buffer (1/2/4-byte loads and stores). Each
//          transaction is serialised into byte beats; ties are resolved
//          round-robin. Honours flush (reads only) and IO back-pressure.
// Ports:
//   clk_in          clock
//   rst_in          asynchronous active-high reset
//   rdy_in          global enable, low freezes the controller
//   flush           pipeline flush, aborts fetches/loads in flight
//   io_buffer_full  IO region back-pressure for stores
//   bus             mem_arbiter_if.slave: RAM port and both requesters
//
// state | meaning
// IDLE  | no transaction; arbitrate requests at the clock edge
// READ  | N+1 cycles: drive addr+i for i<N, capture byte one cycle later
// WRITE | one store beat per cycle unless stalled by a full IO buffer
// DONE  | one-cycle done pulse with result; back to IDLE
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_HI  = 17
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         flush,
    input  logic         io_buffer_full,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic {SRC_IF = 1'b0, SRC_LS = 1'b1} src_t;

    state_t                state, state_nxt;
    src_t                  last_grant, src, grant_src;
    logic                  grant, grant_wr;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [2:0]            grant_n;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] beat_a;
    logic [2:0]            n_bytes;
    logic [2:0]            idx;
    logic [31:0]           wdata;
    logic [31:0]           result;
    logic                  rd_drive;
    logic                  stall;

    // What the RAM is presenting on mem_din this cycle: the read address
    // driven in the previous cycle. Tracked regardless of rdy_in because the
    // RAM keeps clocking while we are frozen.
    logic                  rd_valid;
    logic [1:0]            rd_lane;

    assign beat_a   = addr + ADDR_WIDTH'(idx);
    assign rd_drive = (state == READ) && (idx < n_bytes);
    assign stall    = (state == WRITE) && (beat_a[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            last_grant <= SRC_IF;
            src        <= SRC_IF;
            addr       <= '0;
            n_bytes    <= '0;
            idx        <= '0;
            wdata      <= '0;
            result     <= '0;
            rd_valid   <= 1'b0;
            rd_lane    <= '0;
        end else begin
            rd_valid <= rd_drive;
            rd_lane  <= idx[1:0];
            if (rd_valid) begin
                result[{rd_lane, 3'b000} +: 8] <= bus.mem_din;
            end
            if (rdy_in) begin
                state <= state_nxt;
                if (grant) begin
                    src        <= grant_src;
                    last_grant <= grant_src;
                    addr       <= grant_addr;
                    n_bytes    <= grant_n;
                    wdata      <= bus.ls_wdata;
                    idx        <= '0;
                    // zero-extension for short loads; overrides any stale capture
                    result     <= '0;
                end else if (rd_drive) begin
                    idx <= idx + 3'd1;
                end else if (state == WRITE && !stall) begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        grant_src    = SRC_IF;
        grant_addr   = bus.if_addr;
        grant_n      = 3'd4;
        grant_wr     = 1'b0;
        bus.mem_a    = '0;
        bus.mem_dout = '0;
        bus.mem_wr   = 1'b0;
        bus.if_done  = 1'b0;
        bus.if_data  = '0;
        bus.ls_done  = 1'b0;
        bus.ls_rdata = '0;

        if (state == IDLE && !flush) begin
            if (bus.if_req && bus.ls_req) begin
                grant     = 1'b1;
                grant_src = (last_grant == SRC_IF) ? SRC_LS : SRC_IF;
            end else if (bus.ls_req) begin
                grant     = 1'b1;
                grant_src = SRC_LS;
            end else if (bus.if_req) begin
                grant     = 1'b1;
                grant_src = SRC_IF;
            end
        end

        if (grant_src == SRC_LS) begin
            grant_addr = bus.ls_addr;
            grant_wr   = bus.ls_wr;
            case (bus.ls_size)
                2'b00:   grant_n = 3'd1;
                2'b01:   grant_n = 3'd2;
                default: grant_n = 3'd4;
            endcase
        end

        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = grant_wr ? WRITE : READ;
                end
            end
            READ: begin
                if (rd_drive) begin
                    bus.mem_a = beat_a;
                end
                if (flush) begin
                    state_nxt = IDLE;
                end else if (idx == n_bytes) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                bus.mem_a    = beat_a;
                bus.mem_dout = wdata[{idx[1:0], 3'b000} +: 8];
                // No write strobe while frozen, so an IO byte is not emitted
                // repeatedly during a pause.
                bus.mem_wr   = !stall && rdy_in;
                if (!stall && idx == n_bytes - 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (src == SRC_IF) begin
                    bus.if_done = 1'b1;
                    bus.if_data = result;
                end else begin
                    bus.ls_done  = 1'b1;
                    bus.ls_rdata = result;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Purpose: self-checking bench for mem_arbiter with a byte RAM model, a
//          write log and a scoreboard of expected done pulses.
module tb_mem_arbiter;
    localparam int AW = 32;

    logic clk_in         = 1'b0;
    logic rst_in         = 1'b0;
    logic rdy_in         = 1'b1;
    logic flush          = 1'b0;
    logic io_buffer_full = 1'b0;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .IO_SEL_HI(17)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush          (flush),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          is_ls;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [39:0] wlog[$];
    logic [7:0]  ram [0:262143];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // RAM: address sampled at the edge, byte presented during the next cycle
    always @(posedge clk_in) begin
        if (bus.mem_wr) begin
            ram[bus.mem_a[17:0]] <= bus.mem_dout;
            wlog.push_back({bus.mem_a, bus.mem_dout});
        end
        bus.mem_din <= ram[bus.mem_a[17:0]];
    end

    // Scoreboard consumer
    always @(posedge clk_in) begin
        #1;
        if (!rst_in && (bus.if_done || bus.ls_done)) begin
            check_eq("done_onehot", bus.if_done & bus.ls_done, 0);
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("done_src", bus.ls_done, mon_e.is_ls);
                if (mon_e.chk_data) begin
                    check_eq("done_data", bus.ls_done ? bus.ls_rdata : bus.if_data, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!(bus.if_done || bus.ls_done) && guard < 60) begin
            step();
            guard++;
        end
        check_eq("done_seen", bus.if_done || bus.ls_done, 1);
    endtask

    task automatic ls_setup(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd);
        bus.ls_wr    = wr;
        bus.ls_addr  = a;
        bus.ls_size  = sz;
        bus.ls_wdata = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.ls_req = 1'b0;
        ls_setup(1'b0, 32'h0, 2'b00, 32'h0);
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'hA0; ram[18'h103] = 8'h00;
        ram[18'h200] = 8'hEF; ram[18'h201] = 8'hBE; ram[18'h202] = 8'hAD; ram[18'h203] = 8'hDE;

        // reset values
        #1 rst_in = 1'b1;
        #1;
        check_eq("rst_mem_a", bus.mem_a, 0);
        check_eq("rst_mem_wr", bus.mem_wr, 0);
        check_eq("rst_mem_dout", bus.mem_dout, 0);
        check_eq("rst_done", {bus.if_done, bus.ls_done}, 0);
        check_eq("rst_data", {bus.if_data, bus.ls_rdata}, 0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        step();

        // tie after reset: LS, then IF, then LS again
        cyc = 0;
        bus.if_addr = 32'h100;
        ls_setup(1'b0, 32'h200, 2'b10, 32'h0);
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
        sb.push_back('{1'b0, 1'b1, 32'h00A00513});
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        wait_done();
        check_eq("tie1_lat", cyc, 6);
        step();
        wait_done();
        check_eq("tie2_lat", cyc, 13);
        step();
        wait_done();
        check_eq("tie3_lat", cyc, 20);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        step();

        // fetch: address sequence and latency
        cyc = 0;
        bus.if_addr = 32'h100;
        sb.push_back('{1'b0, 1'b1, 32'h00A00513});
        bus.if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("fetch_a", bus.mem_a, 32'h100 + k);
        end
        wait_done();
        check_eq("fetch_lat", cyc, 6);
        bus.if_req = 1'b0;
        step();
        check_eq("fetch_idle_a", bus.mem_a, 0);

        // half store across the IO-selector boundary
        ram[18'h20001] = 8'h5A;
        wlog.delete();
        cyc = 0;
        ls_setup(1'b1, 32'h1FFFF, 2'b01, 32'hAABBCCDD);
        sb.push_back('{1'b1, 1'b0, 32'h0});
        bus.ls_req = 1'b1;
        wait_done();
        check_eq("sth_lat", cyc, 3);
        bus.ls_req = 1'b0;
        step();
        check_eq("sth_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check_eq("sth_w0", wlog[0], {32'h1FFFF, 8'hDD});
            check_eq("sth_w1", wlog[1], {32'h20000, 8'hCC});
        end
        check_eq("sth_untouched", ram[18'h20001], 8'h5A);

        // IO stall for three cycles
        wlog.delete();
        io_buffer_full = 1'b1;
        cyc = 0;
        ls_setup(1'b1, 32'h30000, 2'b00, 32'h00000077);
        sb.push_back('{1'b1, 1'b0, 32'h0});
        bus.ls_req = 1'b1;
        repeat (3) begin
            step();
            check_eq("io_stall_wr", bus.mem_wr, 0);
        end
        step();
        io_buffer_full = 1'b0;
        #1;
        check_eq("io_wr", bus.mem_wr, 1);
        check_eq("io_a", bus.mem_a, 32'h30000);
        check_eq("io_dout", bus.mem_dout, 8'h77);
        wait_done();
        check_eq("io_lat", cyc, 5);
        bus.ls_req = 1'b0;
        step();
        check_eq("io_nwr", wlog.size(), 1);

        // flush in the 3rd READ cycle of a fetch
        cyc = 0;
        bus.if_addr = 32'h100;
        bus.if_req = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        step();
        check_eq("flush_rd_done", bus.if_done, 0);
        check_eq("flush_rd_a", bus.mem_a, 0);
        flush = 1'b0;
        bus.if_req = 1'b0;
        repeat (8) step();

        // same flush during a word store is ignored
        wlog.delete();
        cyc = 0;
        ls_setup(1'b1, 32'h400, 2'b10, 32'h11223344);
        sb.push_back('{1'b1, 1'b0, 32'h0});
        bus.ls_req = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_done();
        check_eq("flush_st_lat", cyc, 5);
        bus.ls_req = 1'b0;
        step();
        check_eq("flush_st_nwr", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check_eq("flush_st_w", wlog[k],
                         {32'h400 + k, 8'h44 - 8'(k * 8'h11)});
            end
        end

        // rdy_in low for 4 cycles mid-load
        cyc = 0;
        ls_setup(1'b0, 32'h200, 2'b10, 32'h0);
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
        bus.ls_req = 1'b1;
        step();
        step();
        check_eq("pause_a0", bus.mem_a, 32'h201);
        rdy_in = 1'b0;
        repeat (4) begin
            step();
            check_eq("pause_hold_a", bus.mem_a, 32'h201);
        end
        rdy_in = 1'b1;
        wait_done();
        check_eq("pause_lat", cyc, 10);
        bus.ls_req = 1'b0;
        step();

        // async reset in the middle of a load
        cyc = 0;
        ls_setup(1'b0, 32'h200, 2'b10, 32'h0);
        bus.ls_req = 1'b1;
        step();
        step();
        check_eq("mid_rst_a_before", bus.mem_a, 32'h201);
        rst_in = 1'b1;
        #1;
        check_eq("mid_rst_a", bus.mem_a, 0);
        check_eq("mid_rst_wr", bus.mem_wr, 0);
        check_eq("mid_rst_done", {bus.if_done, bus.ls_done}, 0);
        check_eq("mid_rst_data", {bus.if_data, bus.ls_rdata}, 0);
        bus.ls_req = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        step();

        // tie after reset again: byte load (zero-extended) wins, then fetch
        cyc = 0;
        bus.if_addr = 32'h100;
        ls_setup(1'b0, 32'h200, 2'b00, 32'h0);
        sb.push_back('{1'b1, 1'b1, 32'h000000EF});
        sb.push_back('{1'b0, 1'b1, 32'h00A00513});
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        wait_done();
        check_eq("byte_lat", cyc, 3);
        bus.ls_req = 1'b0;
        step();
        wait_done();
        bus.if_req = 1'b0;
        repeat (3) step();

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
